// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Default pattern is the classic 10010, LSB-aligned.
package seqdet_pkg;

  localparam logic [7:0] DEF_PAT = 8'b0001_0010;
  localparam int         DEF_LEN = 5;
  localparam bit         DEF_OVL = 1'b1;

  // Ones in bits len-1..0; callers truncate to their pattern width.
  function automatic logic [31:0] len_mask(input logic [31:0] len);
    if (len >= 32'd32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Count is registered, sat is combinational from the count.
module seqdet_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             tst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat = &cnt_q;
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!tst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seqdet_prog.sv
// Programmable serial bit-sequence detector with overlap mode and match counter.
// z pulses one clk after the edge that accepts the completing sample.
module seqdet_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(seqdet_pkg::DEF_PAT),
  parameter int                 DEF_LEN = seqdet_pkg::DEF_LEN,
  parameter bit                 DEF_OVL = seqdet_pkg::DEF_OVL
) (
  input  logic               clk,
  input  logic               tst_n,
  input  logic               x,
  input  logic               x_vld,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   cnt,
  output logic               cnt_sat
);

  import seqdet_pkg::*;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               z_q;
  logic               match;
  logic [MAX_LEN-1:0] hist_sh;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] mask;

  always_comb begin
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match    = 1'b0;
    hist_sh  = {hist_q[MAX_LEN-2:0], x};
    fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    // Bits above len are stale history and must not take part in the compare.
    mask     = MAX_LEN'(len_mask(32'(len_q)));

    if (cfg_we) begin
      pat_d  = cfg_pat;
      ovl_d  = cfg_ovl;
      hist_d = '0;
      fill_d = '0;
      if (cfg_len == '0) begin
        len_d = LEN_W'(1);
      end else if (cfg_len > LEN_W'(MAX_LEN)) begin
        len_d = LEN_W'(MAX_LEN);
      end else begin
        len_d = cfg_len;
      end
    end else if (x_vld && en) begin
      hist_d = hist_sh;
      fill_d = fill_inc;
      match  = (fill_inc >= len_q) && (((hist_sh ^ pat_q) & mask) == '0);
      // Non-overlapping mode: the next match must be built from fresh samples.
      if (match && !ovl_q) begin
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!tst_n) begin
      pat_q  <= DEF_PAT;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVL;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= match;
    end
  end

  assign z = z_q;

  seqdet_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .tst_n(tst_n),
    .clr  (cnt_clr),
    .inc  (match),
    .cnt  (cnt),
    .sat  (cnt_sat)
  );

endmodule

// File: tb/tb_seqdet_prog.sv
// Directed bench for seqdet_prog: driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares z / cnt / cnt_sat.
module tb_seqdet_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 4;

  logic             clk;
  logic             tst_n;
  logic             x;
  logic             x_vld;
  logic             en;
  logic             cfg_we;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic             cnt_clr;
  logic             z;
  logic [CNT_W-1:0] cnt;
  logic             cnt_sat;

  typedef struct {
    logic             z;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    int               id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_id  = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  seqdet_prog #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .tst_n  (tst_n),
    .x      (x),
    .x_vld  (x_vld),
    .en     (en),
    .cfg_we (cfg_we),
    .cfg_pat(cfg_pat),
    .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl),
    .cnt_clr(cnt_clr),
    .z      (z),
    .cnt    (cnt),
    .cnt_sat(cnt_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of stimulus; exp_z is the hand-computed z for the cycle after this edge.
  task automatic step(input logic v_vld, input logic vx, input logic ven,
                      input logic vwe, input logic vclr, input logic vrst_n,
                      input logic exp_z);
    exp_t e;
    x       = vx;
    x_vld   = v_vld;
    en      = ven;
    cfg_we  = vwe;
    cnt_clr = vclr;
    tst_n   = vrst_n;
    if (!vrst_n || vclr) exp_cnt = '0;
    else if (exp_z && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    e.z   = exp_z;
    e.cnt = exp_cnt;
    e.sat = (exp_cnt == '1);
    e.id  = vec_id;
    exp_q.push_back(e);
    vec_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic b, input logic exp_z);
    step(1'b1, b, 1'b1, 1'b0, 1'b0, 1'b1, exp_z);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rst_cycle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pat = p;
    cfg_len = l;
    cfg_ovl = o;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: one expectation per driven cycle, checked away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (z !== e.z) begin
          n_fail++;
          $display("FAIL z vec=%0d got=%b exp=%b", e.id, z, e.z);
        end
        n_tests++;
        if (cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL cnt vec=%0d got=%0d exp=%0d", e.id, cnt, e.cnt);
        end
        n_tests++;
        if (cnt_sat !== e.sat) begin
          n_fail++;
          $display("FAIL cnt_sat vec=%0d got=%b exp=%b", e.id, cnt_sat, e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    x = 1'b0; x_vld = 1'b0; en = 1'b1; cfg_we = 1'b0; cnt_clr = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0; tst_n = 1'b0;
    #1;

    // 1: reset defaults detect 10010
    rst_cycle(); rst_cycle();
    sample(1, 0); sample(0, 0); sample(0, 0); sample(1, 0); sample(0, 1);
    idle();

    // 2: overlap on, then off
    cfg(8'h12, 4'd5, 1'b1);
    sample(1, 0); sample(0, 0); sample(0, 0); sample(1, 0);
    sample(0, 1); sample(0, 0); sample(1, 0); sample(0, 1);
    cfg(8'h12, 4'd5, 1'b0);
    sample(1, 0); sample(0, 0); sample(0, 0); sample(1, 0);
    sample(0, 1); sample(0, 0); sample(1, 0); sample(0, 0);

    // 3: pattern 110, idle gaps between samples 4 and 5
    cfg(8'h06, 4'd3, 1'b1);
    sample(1, 0); sample(1, 0); sample(0, 1);
    sample(1, 0); idle(); idle(); sample(1, 0); sample(0, 1);
    // cfg_len=0 loads as 1
    cfg(8'h01, 4'd0, 1'b1);
    sample(1, 1); sample(0, 0); sample(1, 1); sample(1, 1);
    // cfg_len above MAX_LEN loads as MAX_LEN
    cfg(8'hFF, 4'd15, 1'b1);
    for (int i = 0; i < 7; i++) sample(1, 0);
    sample(1, 1); sample(1, 1);

    // 4: saturation with 4-bit counter
    cfg(8'h01, 4'd1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) sample(1, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    sample(1, 1);

    // 5: reset mid-stream discards the partial match
    rst_cycle();
    sample(1, 0); sample(0, 0); sample(0, 0); sample(1, 0);
    rst_cycle();
    sample(0, 0);
    sample(1, 0); sample(0, 0); sample(0, 0); sample(1, 0); sample(0, 1);

    // 6: cfg_we drops a concurrent sample and clears history; en=0 holds state
    sample(1, 0); sample(0, 0); sample(0, 0); sample(1, 0);
    cfg_pat = 8'h12; cfg_len = 4'd5; cfg_ovl = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    sample(0, 0);
    sample(1, 0); sample(0, 0); sample(0, 0); sample(1, 0); sample(0, 1);
    sample(1, 0); sample(0, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample(0, 0); sample(1, 0); sample(0, 1);
    idle(); idle();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seqdet_prog.md
Name: seqdet_prog

Overview:
Programmable serial bit-sequence detector. It is the parametrised successor of the fixed "10010" seqdet. Pattern, pattern length and overlap mode are run-time configurable up to MAX_LEN bits, and the block keeps a saturating match counter. It sits on a 1-bit serial sample stream (x qualified by x_vld) and raises a one-cycle pulse on z per detected match.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of cfg_len
CNT_W, 8, match counter width
DEF_PAT, 8'b0001_0010, reset pattern (LSB-aligned; classic 10010)
DEF_LEN, 5, reset pattern length
DEF_OVL, 1, reset overlap mode (1 = overlapping matches allowed)

Ports:
clk  in  1  single clock, all logic rising-edge
tst_n  in  1  synchronous active-low reset
x  in  1  serial data bit
x_vld  in  1  x is a valid sample this cycle
en  in  1  detector enable; when 0, samples are ignored
cfg_we  in  1  load cfg_pat/cfg_len/cfg_ovl this cycle
cfg_pat  in  MAX_LEN  pattern, LSB-aligned; bit len-1 = first bit expected
cfg_len  in  LEN_W  pattern length
cfg_ovl  in  1  overlap mode
cnt_clr  in  1  clear match counter
z  out  1  match pulse
cnt  out  CNT_W  matches since reset/clear, saturating
cnt_sat  out  1  cnt == all ones

Behaviour:
- Reset (tst_n=0 at a clk edge):
  - pat=DEF_PAT, len=DEF_LEN, ovl=DEF_OVL.
  - hist=0, fill=0, z=0, cnt=0, cnt_sat=0.
  - Reset has priority over every other input. Reset mid-stream discards any partial match.
- Accepted sample: x_vld=1 && en=1 && cfg_we=0.
  - hist <= {hist[MAX_LEN-2:0], x}; hist[0] is the newest bit.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the accepted sample including the new bit: fill_next >= len && hist_next[len-1:0] == pat[len-1:0].
- z: registered. It is 1 in the cycle after the clock edge that accepted the completing sample, for exactly one cycle. Latency is 1 clk. z=0 in all other cycles, including non-accepted cycles.
- Overlap mode:
  - ovl=1: fill is kept on a match, so bits of this match may start the next one.
  - ovl=0: fill <= 0 on a match, so the next match needs len fresh samples.
- Config write (cfg_we=1):
  - pat, len and ovl take the new values at the next edge.
  - hist and fill are cleared.
  - A concurrent x_vld sample is dropped.
  - cnt is unaffected.
- cfg_len sanitising at load: 0 is stored as 1; values > MAX_LEN are stored as MAX_LEN.
- en=0: no shift, no fill change, z=0. hist and fill are held, so a match may complete after en returns to 1.
- x_vld gaps: idle cycles between samples do not break a sequence.
- Counter:
  - cnt_clr=1: cnt <= 0. Clear has priority over a same-cycle increment; z still pulses.
  - Otherwise, on a match, cnt <= cnt+1, saturating at 2^CNT_W-1.
  - cnt_sat is combinational from cnt.
- No X propagation: hist bits above len are don't-care for the compare and must be masked.

Decomposition:
- Shared package seqdet_pkg:
  - DEF_PAT/DEF_LEN/DEF_OVL constants.
  - Mask function len -> MAX_LEN-bit mask (1s in bits len-1..0).
- Sub-module seqdet_sat_cnt (CNT_W parameter; ports clk, tst_n, clr, inc, cnt, sat) holds the saturating counter.
- Pattern register, history shift register, fill counter and compare stay in seqdet_prog.

Test Plan:
1. Reset defaults: tst_n low for 2 clk, then samples 1,0,0,1,0 -> z=1 exactly one cycle after the 5th sample edge, cnt=1, cnt_sat=0.
2. Overlap: default config, samples 1,0,0,1,0,0,1,0 -> z pulses after samples 5 and 8, cnt=2. Repeat after cfg_we with cfg_ovl=0 (same pat/len) -> z only after sample 5, cnt increments by 1.
3. Reconfigure: cfg_we with cfg_pat=8'b0000_0110, cfg_len=3, then samples 1,1,0,1,1,0 with 2 idle x_vld=0 cycles between samples 4 and 5 -> z after samples 3 and 6. Also cfg_len=0 loads as 1: pat bit0=1 matches every sample 1.
4. Saturation: CNT_W=4, 16 matches -> cnt=15, cnt_sat=1, 17th match -> cnt stays 15, z still pulses. cnt_clr together with a match -> cnt=0 next cycle, z=1.
5. Reset mid-operation: default config, samples 1,0,0,1, then tst_n=0 for 1 clk, then sample 0 -> no z. Then 1,0,0,1,0 -> z once.
6. Collisions/enable: cfg_we and x_vld in the same cycle -> sample dropped and hist/fill cleared. With en=0, samples are ignored and z=0. Samples 1,0 with en=1, then en=0 for 3 cycles with x_vld=1, then 0,1,0 with en=1 -> z after the final 0.
